// File: rtl/norm_row_sequencer_if.sv
// Stream bundle around norm_row_sequencer: row data and row sum in, {data, sum} beats out, status.
interface norm_row_sequencer_if;
  logic [127:0] S_DATA_TDATA;
  logic         S_DATA_TVALID;
  logic         S_DATA_TREADY;
  logic         S_DATA_TLAST;
  logic [15:0]  S_SUM_TDATA;
  logic         S_SUM_TVALID;
  logic         S_SUM_TREADY;
  logic [143:0] M_AXIS_TDATA;
  logic         M_AXIS_TVALID;
  logic         M_AXIS_TREADY;
  logic         M_AXIS_TLAST;
  logic         busy;
  logic [15:0]  row_count;
  logic         err_len;

  modport slave (
    input  S_DATA_TDATA, S_DATA_TVALID, S_DATA_TLAST, S_SUM_TDATA, S_SUM_TVALID, M_AXIS_TREADY,
    output S_DATA_TREADY, S_SUM_TREADY, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST,
           busy, row_count, err_len
  );

  modport master (
    output S_DATA_TDATA, S_DATA_TVALID, S_DATA_TLAST, S_SUM_TDATA, S_SUM_TVALID, M_AXIS_TREADY,
    input  S_DATA_TREADY, S_SUM_TREADY, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST,
           busy, row_count, err_len
  );
endinterface

// File: rtl/norm_row_sequencer.sv
// Buffers one row of 128-bit beats, waits for its bf16 sum, then replays the row as {data, sum} beats.
// RAM read data register doubles as the output register; reads are only issued when it is free or draining.
module norm_row_sequencer #(
  parameter int BEATS_PER_ROW = 96,
  parameter int ADDR_W        = 8
) (
  input  logic                aclk,
  input  logic                arst,
  norm_row_sequencer_if.slave io
);
  typedef enum logic [1:0] {FILL, WAIT_SUM, DRAIN} state_t;

  localparam int                IDX_W    = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BEATS_PER_ROW - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] rd_cnt;
  logic              sum_held;
  logic [15:0]       sum_reg;
  logic [127:0]      mem [BEATS_PER_ROW];
  logic [127:0]      rd_dat;
  logic              out_vld;
  logic              out_last;
  logic [15:0]       row_cnt;
  logic              err_q;

  logic data_rdy;
  logic sum_rdy;
  logic rd_en;
  logic data_acc;
  logic sum_acc;
  logic wr_last;
  logic rd_last;
  logic out_hs;
  logic row_done;

  assign data_acc = io.S_DATA_TVALID && data_rdy;
  assign sum_acc  = io.S_SUM_TVALID && sum_rdy;
  assign wr_last  = (wr_cnt == LAST_IDX);
  assign rd_last  = (rd_cnt == LAST_IDX);
  assign out_hs   = out_vld && io.M_AXIS_TREADY;
  assign row_done = out_hs && out_last;

  always_ff @(posedge aclk) begin
    if (arst) state <= FILL;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:     if (data_acc && wr_last) state_nxt = (sum_held || sum_acc) ? DRAIN : WAIT_SUM;
      WAIT_SUM: if (sum_acc) state_nxt = DRAIN;
      DRAIN:    if (row_done) state_nxt = FILL;
      default:  state_nxt = FILL;
    endcase
  end

  // Once the last beat sits in the output register no further read is issued for this row.
  always_comb begin
    data_rdy = !arst && (state == FILL);
    sum_rdy  = !arst && !sum_held && (state != DRAIN);
    rd_en    = (state == DRAIN) && !(out_vld && out_last) && (!out_vld || io.M_AXIS_TREADY);
  end

  always_ff @(posedge aclk) begin
    if (data_acc) mem[wr_cnt[IDX_W-1:0]] <= io.S_DATA_TDATA;
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      sum_held <= 1'b0;
      sum_reg  <= '0;
      rd_dat   <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      row_cnt  <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= data_acc && (io.S_DATA_TLAST != wr_last);
      if (data_acc) wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
      if (sum_acc) begin
        sum_reg  <= io.S_SUM_TDATA;
        sum_held <= 1'b1;
      end else if (row_done) begin
        sum_held <= 1'b0;
      end
      if (rd_en) begin
        rd_dat   <= mem[rd_cnt[IDX_W-1:0]];
        out_vld  <= 1'b1;
        out_last <= rd_last;
        rd_cnt   <= rd_last ? '0 : rd_cnt + 1'b1;
      end else if (out_hs) begin
        out_vld  <= 1'b0;
        out_last <= 1'b0;
      end
      if (row_done) row_cnt <= row_cnt + 1'b1;
    end
  end

  assign io.S_DATA_TREADY = data_rdy;
  assign io.S_SUM_TREADY  = sum_rdy;
  assign io.M_AXIS_TDATA  = {rd_dat, sum_reg};
  assign io.M_AXIS_TVALID = out_vld;
  assign io.M_AXIS_TLAST  = out_last;
  assign io.busy          = (state != FILL);
  assign io.row_count     = row_cnt;
  assign io.err_len       = err_q;
endmodule

// File: tb/tb_norm_row_sequencer.sv
// Scoreboard bench: a row/sum pairing model fills an expected-beat queue, a negedge monitor checks the DUT.
module tb_norm_row_sequencer;
  localparam int N = 4;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  s;
    logic         l;
  } beat_t;

  logic aclk = 1'b0;
  logic arst = 1'b1;

  norm_row_sequencer_if ifc ();

  norm_row_sequencer #(.BEATS_PER_ROW(N), .ADDR_W(2)) dut (
    .aclk (aclk),
    .arst (arst),
    .io   (ifc.slave)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t        exp_q[$];
  logic [127:0] part_row[$];
  logic [127:0] full_beats[$];
  logic [15:0]  sum_q[$];
  int           rows_ready = 0;
  int           in_idx = 0;
  logic         err_pend = 1'b0;
  int           exp_rows = 0;
  int           out_hs_cnt = 0;
  logic         stall_prev = 1'b0;
  logic [144:0] stall_snap = '0;
  logic         rst_prev = 1'b0;
  beat_t        mb;
  logic [15:0]  ms;

  int         rdy_mode = 0;
  int         pat_i = 0;
  logic [6:0] rdy_pat = 7'b1101001;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Downstream ready: 0 = always, 1 = fixed toggle pattern, 2 = random, other = left to the test.
  always @(posedge aclk) begin
    #1;
    case (rdy_mode)
      0: ifc.M_AXIS_TREADY = 1'b1;
      1: begin
        ifc.M_AXIS_TREADY = rdy_pat[pat_i];
        pat_i = (pat_i + 1) % 7;
      end
      2: ifc.M_AXIS_TREADY = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  always @(negedge aclk) begin
    chk("row_count", ifc.row_count, exp_rows[15:0]);
    chk("err_len", ifc.err_len, err_pend);
    if (rst_prev) chk("tvalid_after_reset", ifc.M_AXIS_TVALID, 1'b0);
    if (stall_prev) begin
      chk("stall_valid_held", ifc.M_AXIS_TVALID, 1'b1);
      chk("stall_data_stable", {ifc.M_AXIS_TDATA, ifc.M_AXIS_TLAST}, stall_snap);
    end
    if (arst) begin
      chk("data_tready_in_reset", ifc.S_DATA_TREADY, 1'b0);
      chk("sum_tready_in_reset", ifc.S_SUM_TREADY, 1'b0);
      exp_q.delete();
      part_row.delete();
      full_beats.delete();
      sum_q.delete();
      rows_ready = 0;
      in_idx     = 0;
      err_pend   = 1'b0;
      exp_rows   = 0;
      stall_prev = 1'b0;
    end else begin
      if (ifc.busy) chk("data_tready_while_busy", ifc.S_DATA_TREADY, 1'b0);
      err_pend = 1'b0;
      if (ifc.S_DATA_TVALID && ifc.S_DATA_TREADY) begin
        err_pend = (ifc.S_DATA_TLAST != (in_idx == N - 1));
        part_row.push_back(ifc.S_DATA_TDATA);
        in_idx++;
        if (in_idx == N) begin
          foreach (part_row[i]) full_beats.push_back(part_row[i]);
          part_row.delete();
          in_idx = 0;
          rows_ready++;
        end
      end
      if (ifc.S_SUM_TVALID && ifc.S_SUM_TREADY) sum_q.push_back(ifc.S_SUM_TDATA);
      while (rows_ready > 0 && sum_q.size() > 0) begin
        ms = sum_q.pop_front();
        for (int k = 0; k < N; k++) begin
          mb.d = full_beats.pop_front();
          mb.s = ms;
          mb.l = (k == N - 1);
          exp_q.push_back(mb);
        end
        rows_ready--;
      end
      if (ifc.M_AXIS_TVALID && ifc.M_AXIS_TREADY) begin
        out_hs_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h with nothing expected", ifc.M_AXIS_TDATA);
        end else begin
          mb = exp_q.pop_front();
          chk("out_beat", {ifc.M_AXIS_TDATA, ifc.M_AXIS_TLAST}, {mb.d, mb.s, mb.l});
          if (mb.l) exp_rows++;
        end
      end
      stall_prev = ifc.M_AXIS_TVALID && !ifc.M_AXIS_TREADY;
      stall_snap = {ifc.M_AXIS_TDATA, ifc.M_AXIS_TLAST};
    end
    rst_prev = arst;
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_data(input logic [127:0] d, input logic l, input int gap);
    int t = 0;
    repeat (gap) begin @(posedge aclk); #1; end
    ifc.S_DATA_TDATA  = d;
    ifc.S_DATA_TLAST  = l;
    ifc.S_DATA_TVALID = 1'b1;
    forever begin
      @(negedge aclk);
      if (ifc.S_DATA_TREADY) break;
      t++;
      if (t > 500) begin
        n_tests++; n_fail++;
        $display("FAIL data_accept_timeout: got no ready after %0d cycles, expected accept", t);
        break;
      end
    end
    @(posedge aclk); #1;
    ifc.S_DATA_TVALID = 1'b0;
    ifc.S_DATA_TLAST  = 1'b0;
    ifc.S_DATA_TDATA  = '0;
  endtask

  task automatic send_sum(input logic [15:0] s, input int gap);
    int t = 0;
    repeat (gap) begin @(posedge aclk); #1; end
    ifc.S_SUM_TDATA  = s;
    ifc.S_SUM_TVALID = 1'b1;
    forever begin
      @(negedge aclk);
      if (ifc.S_SUM_TREADY) break;
      t++;
      if (t > 500) begin
        n_tests++; n_fail++;
        $display("FAIL sum_accept_timeout: got no ready after %0d cycles, expected accept", t);
        break;
      end
    end
    @(posedge aclk); #1;
    ifc.S_SUM_TVALID = 1'b0;
    ifc.S_SUM_TDATA  = '0;
  endtask

  task automatic wait_idle();
    int t = 0;
    forever begin
      @(negedge aclk);
      if (exp_q.size() == 0 && !ifc.M_AXIS_TVALID && !ifc.busy) break;
      t++;
      if (t > 500) break;
    end
    chk("drain_completes", (t > 500), 1'b0);
    @(posedge aclk); #1;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    @(posedge aclk); #1;
    arst = 1'b0;
  endtask

  task automatic send_row(input logic [127:0] base, input int bad_last);
    for (int k = 0; k < N; k++) send_data(base + 128'(k), (bad_last >= 0) ? (k == bad_last) : (k == N - 1), 0);
  endtask

  initial begin
    int base_cnt;
    ifc.S_DATA_TDATA  = '0;
    ifc.S_DATA_TVALID = 1'b0;
    ifc.S_DATA_TLAST  = 1'b0;
    ifc.S_SUM_TDATA   = '0;
    ifc.S_SUM_TVALID  = 1'b0;
    ifc.M_AXIS_TREADY = 1'b1;
    repeat (3) @(posedge aclk);
    #1 arst = 1'b0;

    @(negedge aclk);
    chk("reset_data_tready", ifc.S_DATA_TREADY, 1'b1);
    chk("reset_sum_tready", ifc.S_SUM_TREADY, 1'b1);
    chk("reset_busy", ifc.busy, 1'b0);
    chk("reset_tvalid", ifc.M_AXIS_TVALID, 1'b0);
    @(posedge aclk); #1;

    // basic: data first, then sum; latency and bubble-free drain
    send_row(128'h1, -1);
    chk("wait_sum_busy", ifc.busy, 1'b1);
    send_sum(16'h4200, 0);
    chk("drain_entry_busy", ifc.busy, 1'b1);
    chk("drain_entry_tvalid", ifc.M_AXIS_TVALID, 1'b0);
    @(posedge aclk); #1;
    chk("first_tvalid_latency", ifc.M_AXIS_TVALID, 1'b1);
    base_cnt = out_hs_cnt;
    repeat (N) @(negedge aclk);
    #1 chk("no_bubbles", out_hs_cnt - base_cnt, N);
    wait_idle();
    chk("basic_row_count", ifc.row_count, 16'd1);

    // sum before data
    send_sum(16'h3F80, 0);
    chk("sum_held_tready", ifc.S_SUM_TREADY, 1'b0);
    for (int k = 0; k < N; k++) begin
      send_data(128'h10 + 128'(k), k == N - 1, 0);
      chk("sum_tready_low", ifc.S_SUM_TREADY, 1'b0);
    end
    chk("sumfirst_tvalid", ifc.M_AXIS_TVALID, 1'b0);
    @(posedge aclk); #1;
    chk("sumfirst_latency", ifc.M_AXIS_TVALID, 1'b1);
    wait_idle();
    chk("sum_tready_after_drain", ifc.S_SUM_TREADY, 1'b1);

    // backpressure pattern
    pat_i = 0;
    rdy_mode = 1;
    send_row({$urandom, $urandom, $urandom, $urandom}, -1);
    send_sum(16'h40A0, 0);
    wait_idle();
    rdy_mode = 0;

    // TLAST on beat 1 instead of beat 3
    send_row(128'h20, 1);
    send_sum(16'h4100, 0);
    wait_idle();
    chk("row_count_four", ifc.row_count, 16'd4);

    // reset after two of four beats have been taken
    do_reset();
    rdy_mode = 3;
    ifc.M_AXIS_TREADY = 1'b0;
    send_row(128'hA0, -1);
    send_sum(16'h4140, 0);
    repeat (3) @(posedge aclk);
    #1;
    base_cnt = out_hs_cnt;
    ifc.M_AXIS_TREADY = 1'b1;
    for (int t = 0; t < 50 && out_hs_cnt < base_cnt + 2; t++) begin
      @(posedge aclk); #1;
    end
    chk("two_beats_before_reset", out_hs_cnt - base_cnt, 2);
    ifc.M_AXIS_TREADY = 1'b0;
    arst = 1'b1;
    @(posedge aclk); #1;
    arst = 1'b0;
    chk("mid_drain_reset_tvalid", ifc.M_AXIS_TVALID, 1'b0);
    chk("mid_drain_reset_busy", ifc.busy, 1'b0);
    chk("mid_drain_reset_rows", ifc.row_count, 16'd0);
    rdy_mode = 0;
    send_row(128'h4, -1);
    send_sum(16'h4000, 0);
    wait_idle();
    chk("after_reset_rows", ifc.row_count, 16'd1);

    // back-to-back rows with inputs always valid
    do_reset();
    fork
      for (int k = 0; k < 3 * N; k++) send_data(128'h300 + 128'(k), (k % N) == N - 1, 0);
      for (int r = 0; r < 3; r++) send_sum(16'h4400 + 16'(r), 0);
    join
    wait_idle();
    chk("b2b_row_count", ifc.row_count, 16'd3);

    // random rows, random gaps, random downstream ready, occasional bad TLAST
    rdy_mode = 2;
    fork
      for (int k = 0; k < 5 * N; k++)
        send_data({$urandom, $urandom, $urandom, $urandom},
                  ((k % N) == N - 1) ^ ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
      for (int r = 0; r < 5; r++) send_sum(16'($urandom), $urandom_range(0, 6));
    join
    wait_idle();
    chk("random_row_count", ifc.row_count, 16'd8);
    rdy_mode = 0;

    repeat (2) @(posedge aclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    n_fail++;
    $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/norm_row_sequencer.md
Name: norm_row_sequencer

Overview:
- Row-level scheduler that feeds the 144-bit zero-mean/mean-square datapath.
- Buffers one full row of 128-bit data beats (8 bf16 each) arriving on one stream, and waits for that row's bf16 sum arriving on a separate stream.
- Replays the buffered row as {data, sum} beats so every beat of a row carries the same row sum.
- Sits between the row-sum reduction stage and the mean-processing datapath.

Parameters:
- BEATS_PER_ROW, 96: beats per row (768 bf16 / 8); fixed row length. Legal range 2..256.
- ADDR_W, 8: buffer address width; must satisfy 2^ADDR_W >= BEATS_PER_ROW.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- arst  in  1  synchronous active-high reset.
- S_DATA_TDATA  in  128  8 bf16 elements, element i at [16i+15:16i].
- S_DATA_TVALID  in  1  data beat valid.
- S_DATA_TREADY  out  1  data beat accepted when VALID&READY.
- S_DATA_TLAST  in  1  producer's end-of-row marker; checked only.
- S_SUM_TDATA  in  16  bf16 row sum.
- S_SUM_TVALID  in  1  sum valid.
- S_SUM_TREADY  out  1  sum accepted when VALID&READY.
- M_AXIS_TDATA  out  144  {data[127:0], sum[15:0]}.
- M_AXIS_TVALID  out  1  output beat valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TLAST  out  1  high on final beat of a row.
- busy  out  1  high in WAIT_SUM or DRAIN.
- row_count  out  16  rows fully drained; wraps 0xFFFF->0.
- err_len  out  1  one-cycle pulse on TLAST mismatch.

Behaviour:
- Reset:
  - Active when arst is sampled high; synchronous.
  - Clears wr_cnt, rd_cnt, sum_held, row_count, all outputs and the output register; state=FILL.
  - S_DATA_TREADY and S_SUM_TREADY are 0 during any cycle with arst high.
  - Reset mid-row or mid-drain discards buffer contents and any held sum; no partial beat is emitted afterwards.
- Buffer: single-port-write, single-port-read RAM, BEATS_PER_ROW x 128. Holds one row only; no overlap of fill and drain.
- States: FILL, WAIT_SUM, DRAIN.
- FILL:
  - S_DATA_TREADY=1.
  - Each accepted beat writes mem[wr_cnt] and increments wr_cnt.
  - Accepting beat index BEATS_PER_ROW-1 resets wr_cnt to 0. Next state is DRAIN if a sum is held or accepted in the same cycle; otherwise WAIT_SUM.
- Sum capture:
  - S_SUM_TREADY = !sum_held && (state==FILL || state==WAIT_SUM).
  - An accepted sum is latched into sum_reg and sets sum_held.
  - A sum arriving before any data of the row is legal.
  - A simultaneous last-data beat and sum acceptance goes directly to DRAIN.
- WAIT_SUM: S_DATA_TREADY=0. Sum acceptance moves the block to DRAIN next cycle.
- DRAIN:
  - Read latency is one cycle. M_AXIS_TVALID rises on the first cycle after DRAIN is entered.
  - Output register is refilled by read-ahead, so with TREADY held high one beat issues per cycle with no bubbles.
  - Beat k = {mem[k], sum_reg}. M_AXIS_TLAST=1 only for k=BEATS_PER_ROW-1.
  - While TVALID&!TREADY, TDATA and TLAST hold stable. TVALID never drops without a handshake.
  - Handshake of the last beat: TVALID=0 next cycle, sum_held cleared, row_count+1, rd_cnt=0, state=FILL.
  - Both input TREADYs are 0 throughout DRAIN.
- Length check:
  - Row length is set by the counter only; TLAST never shortens or extends a row.
  - err_len pulses for one cycle after any accepted beat where S_DATA_TLAST != (wr_cnt==BEATS_PER_ROW-1).
- busy = (state != FILL).
- Latency, last input accepted (data or sum) at edge T: state=DRAIN at T+1, first M_AXIS_TVALID at T+2.
- Throughput: BEATS_PER_ROW input cycles plus BEATS_PER_ROW+2 output cycles per row.

Test Plan (BEATS_PER_ROW=4 in bench):
- Basic: data beats D0..D3 (0x...0001..0x...0004) with TLAST on D3, then sum 0x4200, TREADY=1 -> four outputs {Dk,0x4200} on consecutive cycles, TLAST on 4th only, first TVALID 2 cycles after sum handshake, row_count=1.
- Sum-first: sum 0x3F80 accepted before D0, then D0..D3 -> DRAIN entered without WAIT_SUM, S_SUM_TREADY stays 0 until the row drains, outputs carry 0x3F80.
- Backpressure: M_AXIS_TREADY toggled 1,0,0,1,0,1,1 -> each beat emitted exactly once in order, TDATA stable while stalled, no TVALID drop.
- Length error: TLAST on D1 and none on D3 -> err_len pulses after D1 and after D3, row still drains 4 beats, TLAST on beat 3.
- Reset mid-drain: arst high for one cycle after 2 of 4 beats handshake -> TVALID=0, row_count unchanged, next row D4..D7 with sum 0x4000 outputs only new data.
- Back-to-back rows: 3 rows, inputs always valid -> row_count=3, S_DATA_TREADY low during each WAIT_SUM/DRAIN, sums never mixed across rows.
